// File: rtl/fp_to_int_conv.sv
// ---------------------------------------------------------------------------
// fp_to_int_conv
//
// Converts the team's 32-bit custom float into a signed 32-bit two's-complement
// integer. The conversion truncates toward zero. It works iteratively: the
// significand is moved into place one bit position per clock cycle.
//
// Float layout:
//   [31]    sign
//   [30:25] biased exponent (unbiased E = exp_field - EXP_BIAS)
//   [24:0]  fraction, with an implicit leading 1 above bit 24
//
// Parameters:
//   EXP_BIAS  exponent bias
//   SATURATE  1: overflow clamps to 0x7FFF_FFFF / 0x8000_0000
//             0: overflow returns 0
//
// Ports:
//   clock_100kHz  in   single clock, rising edge
//   reset         in   synchronous active-high reset
//   start         in   conversion request, only looked at while idle
//   op_in         in   float operand, captured when start is accepted
//   busy          out  high from the accept edge until the result edge
//   done          out  one-cycle pulse marking a new int_out/status_out
//   int_out       out  signed integer result, held until the next result
//   status_out    out  0 exact, 1 overflow, 2 underflow, 3 inexact
//   qual_lugar    out  current state: IDLE=0, UNPACK=1, SHIFT=2, FINISH=3
// ---------------------------------------------------------------------------
module fp_to_int_conv #(
  parameter int EXP_BIAS = 31,
  parameter bit SATURATE = 1'b1
) (
  input  logic        clock_100kHz,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] op_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] int_out,
  output logic [3:0]  status_out,
  output logic [2:0]  qual_lugar
);

  // State encoding; the values are visible on qual_lugar.
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] UNPACK = 3'd1;
  localparam logic [2:0] SHIFT  = 3'd2;
  localparam logic [2:0] FINISH = 3'd3;

  // Status codes shared with the float adder's status_out.
  localparam logic [3:0] STAT_EXACT   = 4'd0;
  localparam logic [3:0] STAT_OVERFLW = 4'd1;
  localparam logic [3:0] STAT_UNDERFL = 4'd2;
  localparam logic [3:0] STAT_INEXACT = 4'd3;

  // The significand has 25 fractional bits. An unbiased exponent of 25 means
  // the integer value is already sitting at bit 0 of the accumulator.
  localparam logic signed [7:0] BIAS_S      = 8'(EXP_BIAS);
  localparam logic signed [7:0] RIGHT_POINT = 8'sd25;
  localparam logic signed [7:0] MAX_EXP     = 8'sd31;

  localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_NEG = 32'h8000_0000;

  logic [2:0]  state_q,  state_d;
  logic [31:0] op_q,     op_d;
  logic [31:0] acc_q,    acc_d;
  logic [4:0]  cnt_q,    cnt_d;
  logic        left_q,   left_d;
  logic        sticky_q, sticky_d;
  logic        ovf_q,    ovf_d;
  logic        unf_q,    unf_d;
  logic        done_q,   done_d;
  logic [31:0] int_q,    int_d;
  logic [3:0]  status_q, status_d;

  // Fields of the latched operand and the quantities derived from them.
  logic                signBit;
  logic [5:0]          expField;
  logic [24:0]         fracField;
  logic signed [7:0]   expUnb;
  logic signed [7:0]   shiftDiff;
  logic [4:0]          shiftCnt;
  logic                isZeroClass;
  logic                isUnderflow;
  logic                isOverflow;
  logic [31:0]         accSigned;
  logic [31:0]         satValue;

  assign signBit   = op_q[31];
  assign expField  = op_q[30:25];
  assign fracField = op_q[24:0];

  // Unbiased exponent. The 6-bit field is widened to 8 bits so that the full
  // range E = -EXP_BIAS .. 63-EXP_BIAS fits as a signed value.
  assign expUnb = $signed({2'b00, expField}) - BIAS_S;

  // Distance between the current binary point and an integer result.
  // A positive value means shift right; a negative value means shift left.
  assign shiftDiff = RIGHT_POINT - expUnb;
  assign shiftCnt  = shiftDiff[7] ? 5'(-shiftDiff) : 5'(shiftDiff);

  assign isZeroClass = (expField == 6'd0);
  assign isUnderflow = expUnb < 8'sd0;

  // Only -2^31 may use E == 31. Every other value with E >= 31 cannot be
  // represented in 32-bit two's complement.
  assign isOverflow = (expUnb > MAX_EXP) ||
                      ((expUnb == MAX_EXP) && !(signBit && (fracField == 25'd0)));

  // Negation of -2^31 wraps back onto itself, which is the correct result.
  assign accSigned = signBit ? (~acc_q + 32'd1) : acc_q;

  assign satValue = SATURATE ? (signBit ? SAT_NEG : SAT_POS) : 32'd0;

  // Next-state logic for the whole datapath.
  // IDLE latches the operand. UNPACK classifies the operand and loads the
  // accumulator and shift count. SHIFT moves one bit per cycle. FINISH
  // applies the sign, picks the status and publishes the result together
  // with the done pulse.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    sticky_d = sticky_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    done_d   = 1'b0;
    int_d    = int_q;
    status_d = status_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d     = op_in;
          acc_d    = 32'd0;
          cnt_d    = 5'd0;
          left_d   = 1'b0;
          sticky_d = 1'b0;
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
          state_d  = UNPACK;
        end
      end

      UNPACK: begin
        acc_d = 32'd0;
        if (isZeroClass) begin
          // A zero exponent field encodes zero when the fraction is empty.
          // A non-empty fraction is too small to reach 1, so it underflows.
          unf_d   = (fracField != 25'd0);
          state_d = FINISH;
        end else if (isUnderflow) begin
          unf_d   = 1'b1;
          state_d = FINISH;
        end else if (isOverflow) begin
          ovf_d   = 1'b1;
          state_d = FINISH;
        end else begin
          acc_d   = {6'd0, 1'b1, fracField};
          cnt_d   = shiftCnt;
          left_d  = shiftDiff[7];
          state_d = (shiftCnt == 5'd0) ? FINISH : SHIFT;
        end
      end

      SHIFT: begin
        if (left_q) begin
          acc_d = {acc_q[30:0], 1'b0};
        end else begin
          // Any 1 that leaves on the right makes the result inexact.
          acc_d    = {1'b0, acc_q[31:1]};
          sticky_d = sticky_q | acc_q[0];
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        // Status priority: overflow, then underflow, then inexact, then exact.
        if (ovf_q) begin
          int_d    = satValue;
          status_d = STAT_OVERFLW;
        end else if (unf_q) begin
          int_d    = 32'd0;
          status_d = STAT_UNDERFL;
        end else begin
          int_d    = accSigned;
          status_d = sticky_q ? STAT_INEXACT : STAT_EXACT;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers. Reset is synchronous and clears everything. A
  // conversion in flight is dropped without a done pulse.
  always_ff @(posedge clock_100kHz) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= 32'd0;
      acc_q    <= 32'd0;
      cnt_q    <= 5'd0;
      left_q   <= 1'b0;
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      done_q   <= 1'b0;
      int_q    <= 32'd0;
      status_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      done_q   <= done_d;
      int_q    <= int_d;
      status_q <= status_d;
    end
  end

  // busy covers the span from the accept edge to the result edge. That span
  // is exactly the time spent outside IDLE.
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign int_out    = int_q;
  assign status_out = status_q;
  assign qual_lugar = state_q;

endmodule

// File: doc/fp_to_int_conv.md
Name: fp_to_int_conv

Overview:
- Iterative converter from the team's 32-bit custom float to a signed 32-bit two's-complement integer.
- Float layout: sign [31], 6-bit biased exponent [30:25], 25-bit fraction [24:0] with implicit leading 1.
- Sits at the output end of the float datapath and decodes adder results into integer form for downstream logic.
- Uses truncation toward zero, an optional saturating overflow, and status codes identical to the adder's status_out encoding.

Parameters:
- EXP_BIAS, 31, exponent bias. Unbiased E = exp_field - EXP_BIAS.
- SATURATE, 1, overflow result: 1 = clamp to 0x7FFF_FFFF / 0x8000_0000; 0 = output 0.

Ports:
- clock_100kHz  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op_in  in  32  float operand; captured on the edge where start is accepted.
- busy  out  1  high from the accept edge until the result edge.
- done  out  1  one-cycle pulse; int_out and status_out are valid from this cycle.
- int_out  out  32  signed integer result; held until the next result.
- status_out  out  4  0 exact, 1 overflow, 2 underflow, 3 inexact; held with int_out.
- qual_lugar  out  3  state debug: IDLE=0, UNPACK=1, SHIFT=2, FINISH=3.

Behaviour:
- Reset: on any edge with reset=1, state goes to IDLE. busy, done, int_out, status_out and qual_lugar become 0, and all internal registers clear. Reset overrides an operation in progress; that result is discarded and done is never pulsed.
- IDLE:
  - If start=1: latch op_in, set busy=1, go to UNPACK.
  - Otherwise stay in IDLE. start while busy is ignored and not queued.
- UNPACK:
  - sig = {1, frac} (26 bits, 25 fractional bits). Compute E.
  - Zero class, exp_field==0: result 0; status 0 if frac==0, else 2. Go to FINISH.
  - E<0: result 0, status 2. Go to FINISH.
  - E>31, or E==31 and not (sign=1 and frac==0): overflow, status 1. Go to FINISH.
  - Otherwise, load a 32-bit accumulator with sig and a shift counter n = |25-E|. Direction is right if E<25, left if E>25. n==0 goes to FINISH, else SHIFT.
- SHIFT:
  - Shift one bit per cycle and decrement n; leave for FINISH when n reaches 0.
  - Right shifts OR each bit shifted out into a sticky flag. Left shifts fill with 0.
  - Maximum n is 25 right (E=0) or 6 left (E=31).
- FINISH:
  - Apply sign by two's complement when sign=1.
  - Register int_out and status_out, pulse done=1, set busy=0, go to IDLE.
  - Status priority: overflow > underflow > inexact (sticky=1) > exact.
  - Overflow int_out: SATURATE=1 gives 0x7FFF_FFFF for positive, 0x8000_0000 for negative; SATURATE=0 gives 0.
- Latency:
  - done is high in the cycle after edge n+2, counting the accept edge as edge 0.
  - The n=0 path takes 2 edges; the maximum is 27 edges.
- Back-to-back: start may be asserted during the done cycle and is accepted, because the state is IDLE.
- Outputs: done is never high for more than one cycle. int_out and status_out change only on FINISH or reset.

Test Plan:
- Exact integer: op_in=0x4500_0000 (+12) -> int_out=0x0000_000C, status 0, n=22, done 24 cycles after accept, qual_lugar walks 1,2,3.
- Negative fraction: op_in=0xC080_0000 (-2.5) -> int_out=0xFFFF_FFFE (-2), status 3.
- Overflow: op_in=0x7E00_0000 -> int_out=0x7FFF_FFFF, status 1, done 2 cycles after accept. With SATURATE=0 -> 0x0000_0000, status 1.
- Boundary:
  - op_in=0xFC00_0000 (-2^31) -> 0x8000_0000, status 0, n=6 left, done at 8 cycles.
  - op_in=0x7C00_0000 (+2^31) -> status 1.
- Underflow/zero:
  - op_in=0x3D00_0000 (0.75) -> 0, status 2.
  - op_in=0x0000_0000 -> 0, status 0.
  - op_in=0x0000_0001 -> 0, status 2.
- Control:
  - start pulsed while busy is ignored; the first result is unchanged.
  - Back-to-back start in the done cycle is accepted.
  - reset=1 mid-SHIFT -> next cycle all outputs 0, state IDLE, no done pulse.
